// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined M-extension multiplier: op encodings
// and the final result-select helper.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam int MAX_XLEN = 64;
  localparam int MAX_PW   = 2 * MAX_XLEN + 2;

  // The product arrives sign-extended to the widest supported size, so one
  // helper serves both XLEN values; the caller truncates to its own XLEN.
  function automatic logic [MAX_XLEN-1:0] mul_sel_result(
    input logic [MAX_PW-1:0] p,
    input mul_op_e           op,
    input logic              word,
    input int                xlen
  );
    logic [MAX_XLEN-1:0] r;
    r = '0;
    if (word) begin
      r = {{32{p[31]}}, p[31:0]};
    end else if (op == MUL) begin
      r = p[MAX_XLEN-1:0];
    end else if (xlen == 32) begin
      r = {32'b0, p[63:32]};
    end else begin
      r = p[127:64];
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_part4.sv
// Splits two (2*HALF+1)-bit signed operands into an unsigned low half and a
// signed high part, and forms the four cross products combinationally.
module mul_part4 #(
  parameter int HALF = 16
) (
  input  logic        [2*HALF:0]   a,
  input  logic        [2*HALF:0]   b,
  output logic        [2*HALF-1:0] ll,
  output logic signed [2*HALF+1:0] lh,
  output logic signed [2*HALF+1:0] hl,
  output logic signed [2*HALF+1:0] hh
);

  localparam int PPW = 2 * HALF + 2;

  logic [PPW-1:0] a_lo_x;
  logic [PPW-1:0] a_hi_x;
  logic [PPW-1:0] b_lo_x;
  logic [PPW-1:0] b_hi_x;

  // Every factor is pre-extended to the product width so the truncated
  // signed multiply is exact.
  assign a_lo_x = {{(HALF+2){1'b0}}, a[HALF-1:0]};
  assign b_lo_x = {{(HALF+2){1'b0}}, b[HALF-1:0]};
  assign a_hi_x = {{(HALF+1){a[2*HALF]}}, a[2*HALF:HALF]};
  assign b_hi_x = {{(HALF+1){b[2*HALF]}}, b[2*HALF:HALF]};

  assign ll = {{HALF{1'b0}}, a[HALF-1:0]} * {{HALF{1'b0}}, b[HALF-1:0]};
  assign lh = $signed(a_lo_x) * $signed(b_hi_x);
  assign hl = $signed(a_hi_x) * $signed(b_lo_x);
  assign hh = $signed(a_hi_x) * $signed(b_hi_x);

endmodule

// File: rtl/mul_pipe.sv
// Three-stage elastic RISC-V multiplier (MUL/MULH/MULHSU/MULHU, MULW on RV64)
// with valid/ready on both sides, flush, and in-order tagged results.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mul_op_e          in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam int  HALF     = XLEN / 2;
  localparam int  EW       = XLEN + 1;
  localparam int  PW       = 2 * XLEN + 2;
  localparam bit  USE_WORD = (XLEN == 64);

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s3_valid_reg;
  logic s1_acc;
  logic s2_acc;
  logic s3_acc;

  // A stage takes new data when empty or when its contents leave this cycle;
  // the chain makes in_ready combinational from out_ready.
  assign s3_acc   = !s3_valid_reg || out_ready;
  assign s2_acc   = !s2_valid_reg || s3_acc;
  assign s1_acc   = !s1_valid_reg || s2_acc;
  assign in_ready = s1_acc;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      if (s1_acc) s1_valid_reg <= in_valid;
      if (s2_acc) s2_valid_reg <= s1_valid_reg;
      if (s3_acc) s3_valid_reg <= s2_valid_reg;
    end
  end

  // ---------------- S1: operand conditioning ----------------
  logic [XLEN:0] a_ext_next;
  logic [XLEN:0] b_ext_next;
  logic          word_next;

  always_comb begin
    word_next  = USE_WORD && in_word;
    a_ext_next = {((in_op == MULH) || (in_op == MULHSU)) && in_a[XLEN-1], in_a};
    b_ext_next = {(in_op == MULH) && in_b[XLEN-1], in_b};
    if (word_next) begin
      a_ext_next = EW'($signed(in_a[31:0]));
      b_ext_next = EW'($signed(in_b[31:0]));
    end
  end

  logic [XLEN:0]      s1_a_reg;
  logic [XLEN:0]      s1_b_reg;
  mul_op_e            s1_op_reg;
  logic               s1_word_reg;
  logic [TAG_W-1:0]   s1_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_reg    <= '0;
      s1_b_reg    <= '0;
      s1_op_reg   <= MUL;
      s1_word_reg <= 1'b0;
      s1_tag_reg  <= '0;
    end else if (s1_acc && in_valid) begin
      s1_a_reg    <= a_ext_next;
      s1_b_reg    <= b_ext_next;
      s1_op_reg   <= in_op;
      s1_word_reg <= word_next;
      s1_tag_reg  <= in_tag;
    end
  end

  // ---------------- S2: partial products ----------------
  logic        [XLEN-1:0] pp_ll_next;
  logic signed [XLEN+1:0] pp_lh_next;
  logic signed [XLEN+1:0] pp_hl_next;
  logic signed [XLEN+1:0] pp_hh_next;

  mul_part4 #(
    .HALF (HALF)
  ) u_part4 (
    .a  (s1_a_reg),
    .b  (s1_b_reg),
    .ll (pp_ll_next),
    .lh (pp_lh_next),
    .hl (pp_hl_next),
    .hh (pp_hh_next)
  );

  logic        [XLEN-1:0]  s2_ll_reg;
  logic signed [XLEN+1:0]  s2_lh_reg;
  logic signed [XLEN+1:0]  s2_hl_reg;
  logic signed [XLEN+1:0]  s2_hh_reg;
  mul_op_e                 s2_op_reg;
  logic                    s2_word_reg;
  logic [TAG_W-1:0]        s2_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ll_reg   <= '0;
      s2_lh_reg   <= '0;
      s2_hl_reg   <= '0;
      s2_hh_reg   <= '0;
      s2_op_reg   <= MUL;
      s2_word_reg <= 1'b0;
      s2_tag_reg  <= '0;
    end else if (s2_acc && s1_valid_reg) begin
      s2_ll_reg   <= pp_ll_next;
      s2_lh_reg   <= pp_lh_next;
      s2_hl_reg   <= pp_hl_next;
      s2_hh_reg   <= pp_hh_next;
      s2_op_reg   <= s1_op_reg;
      s2_word_reg <= s1_word_reg;
      s2_tag_reg  <= s1_tag_reg;
    end
  end

  // ---------------- S3: sum and select ----------------
  logic [PW-1:0]   prod_next;
  logic [XLEN-1:0] res_next;

  // ll is unsigned, the other partials are signed and sign-extend here.
  always_comb begin
    prod_next = PW'(s2_ll_reg)
              + (PW'(s2_lh_reg) << HALF)
              + (PW'(s2_hl_reg) << HALF)
              + (PW'(s2_hh_reg) << XLEN);
    res_next  = XLEN'(mul_sel_result(MAX_PW'($signed(prod_next)), s2_op_reg,
                                     s2_word_reg, XLEN));
  end

  logic [XLEN-1:0]  s3_res_reg;
  logic [TAG_W-1:0] s3_tag_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_res_reg <= '0;
      s3_tag_reg <= '0;
    end else if (s3_acc && s2_valid_reg) begin
      s3_res_reg <= res_next;
      s3_tag_reg <= s2_tag_reg;
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_res   = s3_res_reg;
  assign out_tag   = s3_tag_reg;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench: drives an RV32 and an RV64 instance with identical
// stimulus and checks both against a plain-arithmetic multiply model.
module tb_mul_pipe;
  import mul_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        in_valid;
  mul_op_e     in_op;
  logic        in_word;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] out_res32;
  logic [63:0] out_res64;
  logic [4:0]  out_tag32, out_tag64;

  mul_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_op(in_op), .in_word(in_word), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_res(out_res32), .out_tag(out_tag32)
  );

  mul_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_op(in_op), .in_word(in_word), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_res(out_res64), .out_tag(out_tag64)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: extend per the signedness rules, multiply exactly, pick bits.
  function automatic logic [63:0] ref_mul(input int xlen, input mul_op_e op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] av, bv, pr;
    logic [63:0] r;
    bit sa, sb;
    sa = (op == MULH) || (op == MULHSU);
    sb = (op == MULH);
    if (xlen == 64 && word) begin
      av = 130'($signed(a[31:0]));
      bv = 130'($signed(b[31:0]));
      pr = av * bv;
      return {{32{pr[31]}}, pr[31:0]};
    end
    if (xlen == 32) begin
      if (sa) av = 130'($signed(a[31:0])); else av = 130'(a[31:0]);
      if (sb) bv = 130'($signed(b[31:0])); else bv = 130'(b[31:0]);
    end else begin
      if (sa) av = 130'($signed(a)); else av = 130'(a);
      if (sb) bv = 130'($signed(b)); else bv = 130'(b);
    end
    pr = av * bv;
    if (op == MUL) r = pr[63:0];
    else if (xlen == 32) r = {32'b0, pr[63:32]};
    else r = pr[127:64];
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One cycle of stimulus; records an expectation if the op is handshaked.
  task automatic drive(input bit v, input mul_op_e op, input bit w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                       input logic [31:0] e32, input logic [63:0] e64,
                       input bit ordy, input bit fl, input bit r, output bit acc);
    in_valid = v; in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tag;
    out_ready = ordy; flush = fl; rst = r;
    @(negedge clk);
    if (!r) begin
      chk("in_ready_match", in_ready64, in_ready32);
      chk("in_ready", in_ready32, (sb_q.size() < 3) || ordy);
    end
    acc = v && in_ready32 && !fl && !r;
    if (acc) sb_q.push_back('{tag, e32, e64});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mul_op_e op, input bit w, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input bit ordy, input bit fl, output bit acc);
    drive(1'b1, op, w, a, b, tag, 32'(ref_mul(32, op, w, a, b)), ref_mul(64, op, w, a, b),
          ordy, fl, 1'b0, acc);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, MUL, 1'b0, 64'h0, 64'h0, 5'd0, 32'h0, 64'h0, ordy, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", sb_q.size(), 0);
  endtask

  // Idle with out_ready high and expect out_valid exactly at cycle valid_at.
  task automatic valid_timing(input int n_cycles, input int valid_at);
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n_cycles; i++) begin
      @(negedge clk);
      chk("valid_timing", out_valid32, (i == valid_at));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops on every output handshake, also checks stall stability.
  initial begin : monitor
    exp_t        e;
    bit          stall_prev;
    logic [31:0] prev32;
    logic [63:0] prev64;
    logic [4:0]  prev_tag;
    stall_prev = 1'b0;
    prev32 = '0; prev64 = '0; prev_tag = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid_match", out_valid64, out_valid32);
        if (stall_prev) begin
          chk("stall_valid", out_valid32, 1);
          chk("stall_res32", out_res32, prev32);
          chk("stall_res64", out_res64, prev64);
          chk("stall_tag", out_tag32, prev_tag);
        end
        if (out_valid32 && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", out_valid32, 0);
          end else begin
            e = sb_q.pop_front();
            chk("res32", out_res32, e.e32);
            chk("res64", out_res64, e.e64);
            chk("tag32", out_tag32, e.tag);
            chk("tag64", out_tag64, e.tag);
            $display("txn tag=%0d res32=0x%08h res64=0x%016h", out_tag32, out_res32, out_res64);
          end
        end
        stall_prev = out_valid32 && !out_ready && !flush && !rst;
        prev32 = out_res32; prev64 = out_res64; prev_tag = out_tag32;
        if (flush || rst) sb_q.delete();
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    bit acc;
    int n;
    int cyc;
    logic [63:0] a, b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = MUL; in_word = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid32", out_valid32, 0);
    chk("reset_out_valid64", out_valid64, 0);
    chk("reset_out_res32", out_res32, 0);
    chk("reset_out_res64", out_res64, 0);
    chk("reset_out_tag", out_tag32, 0);
    chk("reset_in_ready32", in_ready32, 1);
    chk("reset_in_ready64", in_ready64, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single op: latency of three cycles, tag echoed.
    drive(1'b1, MUL, 1'b0, 64'd7, 64'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB,
          ref_mul(64, MUL, 1'b0, 64'd7, 64'hFFFF_FFFD), 1'b1, 1'b0, 1'b0, acc);
    chk("accept_first", acc, 1);
    valid_timing(3, 2);

    // Directed corner values, back to back.
    drive(1'b1, MULH, 1'b0, 64'h8000_0000, 64'h8000_0000, 5'd4, 32'h4000_0000,
          ref_mul(64, MULH, 1'b0, 64'h8000_0000, 64'h8000_0000), 1'b1, 1'b0, 1'b0, acc);
    chk("accept_mulh", acc, 1);
    drive(1'b1, MULHU, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE,
          ref_mul(64, MULHU, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 1'b1, 1'b0, 1'b0, acc);
    chk("accept_mulhu", acc, 1);
    drive(1'b1, MULHSU, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF,
          ref_mul(64, MULHSU, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF), 1'b1, 1'b0, 1'b0, acc);
    chk("accept_mulhsu", acc, 1);
    drive(1'b1, MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd7, 32'hFFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, acc);
    chk("accept_mulw", acc, 1);
    drive(1'b1, MULH, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8,
          32'h0, 64'h4000_0000_0000_0000, 1'b1, 1'b0, 1'b0, acc);
    chk("accept_mulh64", acc, 1);
    drain();

    // Ten back-to-back ops with the consumer stalled in cycles 4..8.
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 40) begin
      a = 64'(n + 1) * 64'h0123_4567_89AB_CDEF;
      b = ~a ^ 64'(n);
      send(mul_op_e'(n % 4), 1'b0, a, b, 5'(10 + n), !(cyc >= 4 && cyc <= 8), 1'b0, acc);
      if (acc) n++;
      cyc++;
    end
    chk("stream_all_issued", n, 10);
    drain();

    // Flush with three ops resident and a fourth offered.
    for (int i = 0; i < 3; i++) begin
      send(MUL, 1'b0, 64'(i + 3), 64'd9, 5'(20 + i), 1'b0, 1'b0, acc);
      chk("fill_accept", acc, 1);
    end
    send(MULHU, 1'b0, 64'd11, 64'd13, 5'd23, 1'b0, 1'b1, acc);
    chk("flush_clears_valid", out_valid32, 0);
    send(MUL, 1'b0, 64'd100, 64'd200, 5'd24, 1'b1, 1'b0, acc);
    chk("accept_after_flush", acc, 1);
    valid_timing(3, 2);

    // Flush with two ops early in the pipe and one handshaking.
    send(MULH, 1'b0, 64'd5, 64'd6, 5'd25, 1'b1, 1'b0, acc);
    send(MULH, 1'b0, 64'd7, 64'd8, 5'd26, 1'b1, 1'b0, acc);
    send(MUL, 1'b0, 64'd9, 64'd10, 5'd27, 1'b1, 1'b1, acc);
    valid_timing(4, -1);

    // Synchronous reset with a result waiting at the output.
    for (int i = 0; i < 3; i++) send(MUL, 1'b0, 64'd3, 64'd5, 5'(28 + i), 1'b0, 1'b0, acc);
    drive(1'b0, MUL, 1'b0, 64'h0, 64'h0, 5'd0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1, acc);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_out_res32", out_res32, 0);
    chk("rst_out_res64", out_res64, 0);
    chk("rst_out_tag", out_tag64, 0);
    chk("rst_in_ready", in_ready32, 1);
    @(posedge clk);
    #1;

    // Randomised traffic with backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      mul_op_e op;
      bit w, v, ordy, fl;
      logic [4:0] tag;
      op   = mul_op_e'($urandom_range(0, 3));
      w    = ($urandom_range(0, 3) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 49) == 0);
      tag  = 5'($urandom_range(0, 31));
      a    = pick_operand();
      b    = pick_operand();
      drive(v, op, w, a, b, tag, 32'(ref_mul(32, op, w, a, b)), ref_mul(64, op, w, a, b),
            ordy, fl, 1'b0, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
